reg16_arbiter: RTL

REG16_ARBITER -- requirements
Module: reg16_arbiter

---
 rtl/reg16_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/reg16_arbiter.sv
// Two-requester round-robin arbiter feeding a single shared output register.
// The output register can be reloaded in the same cycle it is consumed.
module reg16_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             mux_sel,
    output logic [7:0]       xfer_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_src_q, last_src_d;
    logic [7:0]       xfer_count_q, xfer_count_d;

    logic grant;
    logic can_load;
    logic xfer;

    // Round-robin only matters under contention; an idle cycle keeps the pointer.
    always_comb begin
        grant = last_src_q;
        if (a_valid && b_valid) grant = ~last_src_q;
        else if (a_valid)       grant = 1'b0;
        else if (b_valid)       grant = 1'b1;
    end

    assign can_load = !reset && ((state_q == EMPTY) || out_ready);
    assign a_ready  = can_load && a_valid && (grant == 1'b0);
    assign b_ready  = can_load && b_valid && (grant == 1'b1);
    assign xfer     = a_ready || b_ready;

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_src_d   = last_src_q;
        xfer_count_d = xfer_count_q;
        if (reset) begin
            state_d      = EMPTY;
            out_data_d   = '0;
            out_src_d    = 1'b0;
            last_src_d   = 1'b1;
            xfer_count_d = '0;
        end else if (xfer) begin
            state_d      = FULL;
            out_data_d   = grant ? b_data : a_data;
            out_src_d    = grant;
            last_src_d   = grant;
            xfer_count_d = xfer_count_q + 8'd1;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        out_data_q   <= out_data_d;
        out_src_q    <= out_src_d;
        last_src_q   <= last_src_d;
        xfer_count_q <= xfer_count_d;
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign mux_sel    = grant;
    assign xfer_count = xfer_count_q;

endmodule
